// File: rtl/mux2_stream_arbiter_if.sv
// Handshake bundle for the 2:1 stream arbiter: two valid/ready requesters,
// one registered output channel and the mux select / busy status.
interface mux2_stream_arbiter_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] A_DATA;
  logic             A_VALID;
  logic             A_LAST;
  logic             A_READY;
  logic [WIDTH-1:0] B_DATA;
  logic             B_VALID;
  logic             B_LAST;
  logic             B_READY;
  logic [WIDTH-1:0] Z_DATA;
  logic             Z_VALID;
  logic             Z_LAST;
  logic             Z_READY;
  logic             S;
  logic             BUSY;

  modport slave (
    input  A_DATA, A_VALID, A_LAST,
    input  B_DATA, B_VALID, B_LAST,
    input  Z_READY,
    output A_READY, B_READY,
    output Z_DATA, Z_VALID, Z_LAST,
    output S, BUSY
  );

  modport master (
    output A_DATA, A_VALID, A_LAST,
    output B_DATA, B_VALID, B_LAST,
    output Z_READY,
    input  A_READY, B_READY,
    input  Z_DATA, Z_VALID, Z_LAST,
    input  S, BUSY
  );
endinterface

// File: rtl/mux2_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one registered 2:1 output channel
// between requesters A and B; a grant ends on LAST or after MAX_BURST beats.
module mux2_stream_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  mux2_stream_arbiter_if.slave  bus
);

  localparam int                CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  CNT_LIM = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             prio;
  logic             sel_p1;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  logic [WIDTH-1:0] z_data_p1;
  logic             z_last_p1;
  logic             vld_p1;

  logic             free;
  logic             own_valid;
  logic             own_last;
  logic [WIDTH-1:0] own_data;
  logic             accept;
  logic             rel;

  always_comb begin
    free      = !vld_p1 || bus.Z_READY;
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    case (state)
      GNT_A: begin
        own_valid = bus.A_VALID;
        own_last  = bus.A_LAST;
        own_data  = bus.A_DATA;
      end
      GNT_B: begin
        own_valid = bus.B_VALID;
        own_last  = bus.B_LAST;
        own_data  = bus.B_DATA;
      end
      default: ;
    endcase
    accept  = (state != IDLE) && free && own_valid;
    cnt_inc = cnt + CNT_W'(1);
    // LAST and the burst limit on the same beat still give one release.
    rel     = accept && (own_last || (cnt_inc == CNT_LIM));

    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.A_VALID && bus.B_VALID) state_nxt = prio ? GNT_B : GNT_A;
        else if (bus.A_VALID)           state_nxt = GNT_A;
        else if (bus.B_VALID)           state_nxt = GNT_B;
      end
      GNT_A, GNT_B: begin
        if (rel) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prio   <= 1'b0;
      sel_p1 <= 1'b0;
      cnt    <= '0;
    end else begin
      if ((state == IDLE) && (state_nxt != IDLE)) begin
        sel_p1 <= (state_nxt == GNT_B);
        cnt    <= '0;
      end else if (accept) begin
        cnt <= rel ? '0 : cnt_inc;
      end
      if (rel) prio <= (state == GNT_A);
    end
  end

  // Stage p1: single output register, held while downstream stalls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p1    <= 1'b0;
      z_last_p1 <= 1'b0;
      z_data_p1 <= '0;
    end else if (accept) begin
      vld_p1    <= 1'b1;
      z_last_p1 <= own_last;
      z_data_p1 <= own_data;
    end else if (free) begin
      vld_p1    <= 1'b0;
    end
  end

  assign bus.A_READY = (state == GNT_A) && free;
  assign bus.B_READY = (state == GNT_B) && free;
  assign bus.BUSY    = (state != IDLE);
  assign bus.S       = sel_p1;
  assign bus.Z_DATA  = z_data_p1;
  assign bus.Z_VALID = vld_p1;
  assign bus.Z_LAST  = z_last_p1;

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Bench for mux2_stream_arbiter: directed vector tables for the key sequences,
// then randomized traffic against a transaction-level reference model.
module tb_mux2_stream_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mux2_stream_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux2_stream_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       av;
    logic [7:0] ad;
    logic       al;
    logic       bv;
    logic [7:0] bd;
    logic       bl;
    logic       zr;
    logic       ar;
    logic       br;
    logic       busy;
    logic       zv;
    logic [7:0] zd;
    logic       zl;
    logic       s;
  } vec_t;

  vec_t seq[$];

  function automatic vec_t mk(input logic rst, input logic av, input logic [7:0] ad,
                              input logic al, input logic bv, input logic [7:0] bd,
                              input logic bl, input logic zr, input logic ar,
                              input logic br, input logic busy, input logic zv,
                              input logic [7:0] zd, input logic zl, input logic s);
    vec_t v;
    v.rst = rst; v.av = av; v.ad = ad; v.al = al;
    v.bv = bv; v.bd = bd; v.bl = bl; v.zr = zr;
    v.ar = ar; v.br = br; v.busy = busy; v.zv = zv;
    v.zd = zd; v.zl = zl; v.s = s;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic av, input logic [7:0] ad, input logic al,
                       input logic bv, input logic [7:0] bd, input logic bl, input logic zr);
    RST         = rst;
    bus.A_VALID = av; bus.A_DATA = ad; bus.A_LAST = al;
    bus.B_VALID = bv; bus.B_DATA = bd; bus.B_LAST = bl;
    bus.Z_READY = zr;
  endtask

  function automatic logic [13:0] observed();
    return {bus.A_READY, bus.B_READY, bus.BUSY, bus.Z_VALID, bus.Z_DATA, bus.Z_LAST, bus.S};
  endfunction

  task automatic compare(input string nm, input int idx, input logic [13:0] exp);
    logic [13:0] act;
    act = observed();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got ar/br/busy/zv/zd/zl/s=%b/%b/%b/%b/%02h/%b/%b want %b/%b/%b/%b/%02h/%b/%b",
               nm, idx, act[13], act[12], act[11], act[10], act[9:2], act[1], act[0],
               exp[13], exp[12], exp[11], exp[10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic run_seq(input string nm);
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge CLK);
      drive(seq[i].rst, seq[i].av, seq[i].ad, seq[i].al, seq[i].bv, seq[i].bd, seq[i].bl, seq[i].zr);
      #1;
      compare(nm, i, {seq[i].ar, seq[i].br, seq[i].busy, seq[i].zv, seq[i].zd, seq[i].zl, seq[i].s});
    end
    seq.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Reference model: who owns the channel, beats so far in the grant, whose
  // turn it is on a tie, and the beat sitting in the output register.
  int         m_owner;   // 0 none, 1 A, 2 B
  int         m_beats;
  bit         m_prio_b;
  bit         m_s;
  bit         m_zv;
  bit         m_zl;
  logic [7:0] m_zd;

  function automatic void model_reset();
    m_owner = 0; m_beats = 0; m_prio_b = 0; m_s = 0;
    m_zv = 0; m_zl = 0; m_zd = 8'h00;
  endfunction

  function automatic logic [13:0] model_outputs(input bit zr);
    bit can_take;
    can_take = !m_zv || zr;
    return {1'(m_owner == 1 && can_take), 1'(m_owner == 2 && can_take), 1'(m_owner != 0),
            1'(m_zv), m_zd, 1'(m_zl), 1'(m_s)};
  endfunction

  function automatic void model_step(input bit av, input logic [7:0] ad, input bit al,
                                     input bit bv, input logic [7:0] bd, input bit bl,
                                     input bit zr);
    bit         can_take;
    bit         v;
    bit         l;
    logic [7:0] d;
    can_take = !m_zv || zr;
    if (m_owner == 0) begin
      if (can_take) m_zv = 0;
      if (av && bv) m_owner = m_prio_b ? 2 : 1;
      else if (av)  m_owner = 1;
      else if (bv)  m_owner = 2;
      if (m_owner != 0) begin
        m_s     = (m_owner == 2);
        m_beats = 0;
      end
    end else begin
      v = (m_owner == 1) ? av : bv;
      l = (m_owner == 1) ? al : bl;
      d = (m_owner == 1) ? ad : bd;
      if (can_take && v) begin
        m_zv = 1; m_zd = d; m_zl = l;
        m_beats++;
        if (l || m_beats == MAX_BURST) begin
          m_prio_b = (m_owner == 1);
          m_owner  = 0;
          m_beats  = 0;
        end
      end else if (can_take) begin
        m_zv = 0;
      end
    end
  endfunction

  initial begin
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    model_reset();
    do_reset();

    // Single A packet 11,22,33
    seq.push_back(mk(0,1,8'h11,0, 0,8'h00,0, 1,  0,0,0, 0,8'h00,0, 0));
    seq.push_back(mk(0,1,8'h11,0, 0,8'h00,0, 1,  1,0,1, 0,8'h00,0, 0));
    seq.push_back(mk(0,1,8'h22,0, 0,8'h00,0, 1,  1,0,1, 1,8'h11,0, 0));
    seq.push_back(mk(0,1,8'h33,1, 0,8'h00,0, 1,  1,0,1, 1,8'h22,0, 0));
    seq.push_back(mk(0,0,8'h00,0, 0,8'h00,0, 1,  0,0,0, 1,8'h33,1, 0));
    seq.push_back(mk(0,0,8'h00,0, 0,8'h00,0, 1,  0,0,0, 0,8'h33,1, 0));
    run_seq("a_packet");

    do_reset();
    // Contention with 1-beat packets: A, B, A
    seq.push_back(mk(0,1,8'hA0,1, 1,8'hB0,1, 1,  0,0,0, 0,8'h00,0, 0));
    seq.push_back(mk(0,1,8'hA1,1, 1,8'hB1,1, 1,  1,0,1, 0,8'h00,0, 0));
    seq.push_back(mk(0,1,8'hA2,1, 1,8'hB2,1, 1,  0,0,0, 1,8'hA1,1, 0));
    seq.push_back(mk(0,1,8'hA3,1, 1,8'hB3,1, 1,  0,1,1, 0,8'hA1,1, 1));
    seq.push_back(mk(0,1,8'hA4,1, 1,8'hB4,1, 1,  0,0,0, 1,8'hB3,1, 1));
    seq.push_back(mk(0,1,8'hA5,1, 1,8'hB5,1, 1,  1,0,1, 0,8'hB3,1, 0));
    run_seq("contention");

    do_reset();
    // B runs 6 beats without LAST; forced release after 4, A slips in
    seq.push_back(mk(0,0,8'h00,0, 1,8'hB1,0, 1,  0,0,0, 0,8'h00,0, 0));
    seq.push_back(mk(0,1,8'hAA,1, 1,8'hB1,0, 1,  0,1,1, 0,8'h00,0, 1));
    seq.push_back(mk(0,1,8'hAA,1, 1,8'hB2,0, 1,  0,1,1, 1,8'hB1,0, 1));
    seq.push_back(mk(0,1,8'hAA,1, 1,8'hB3,0, 1,  0,1,1, 1,8'hB2,0, 1));
    seq.push_back(mk(0,1,8'hAA,1, 1,8'hB4,0, 1,  0,1,1, 1,8'hB3,0, 1));
    seq.push_back(mk(0,1,8'hAA,1, 1,8'hB5,0, 1,  0,0,0, 1,8'hB4,0, 1));
    seq.push_back(mk(0,1,8'hAA,1, 1,8'hB5,0, 1,  1,0,1, 0,8'hB4,0, 0));
    seq.push_back(mk(0,0,8'h00,0, 1,8'hB5,0, 1,  0,0,0, 1,8'hAA,1, 0));
    seq.push_back(mk(0,0,8'h00,0, 1,8'hB5,0, 1,  0,1,1, 0,8'hAA,1, 1));
    seq.push_back(mk(0,0,8'h00,0, 1,8'hB6,0, 1,  0,1,1, 1,8'hB5,0, 1));
    seq.push_back(mk(0,0,8'h00,0, 0,8'h00,0, 1,  0,1,1, 1,8'hB6,0, 1));
    seq.push_back(mk(0,0,8'h00,0, 0,8'h00,0, 1,  0,1,1, 0,8'hB6,0, 1));
    run_seq("burst_limit");

    do_reset();
    // Backpressure on 5A, then the pointer left at B wins a tie
    seq.push_back(mk(0,1,8'h5A,1, 0,8'h00,0, 1,  0,0,0, 0,8'h00,0, 0));
    seq.push_back(mk(0,1,8'h5A,1, 0,8'h00,0, 1,  1,0,1, 0,8'h00,0, 0));
    seq.push_back(mk(0,1,8'h77,1, 0,8'h00,0, 0,  0,0,0, 1,8'h5A,1, 0));
    seq.push_back(mk(0,1,8'h77,1, 0,8'h00,0, 0,  0,0,1, 1,8'h5A,1, 0));
    seq.push_back(mk(0,1,8'h77,1, 0,8'h00,0, 0,  0,0,1, 1,8'h5A,1, 0));
    seq.push_back(mk(0,1,8'h77,1, 0,8'h00,0, 1,  1,0,1, 1,8'h5A,1, 0));
    seq.push_back(mk(0,0,8'h00,0, 0,8'h00,0, 1,  0,0,0, 1,8'h77,1, 0));
    seq.push_back(mk(0,1,8'h44,1, 1,8'hC3,1, 1,  0,0,0, 0,8'h77,1, 0));
    seq.push_back(mk(0,1,8'h44,1, 1,8'hC3,1, 1,  0,1,1, 0,8'h77,1, 1));
    seq.push_back(mk(0,0,8'h00,0, 0,8'h00,0, 1,  0,0,0, 1,8'hC3,1, 1));
    run_seq("backpressure_prio");

    do_reset();
    // Asynchronous reset mid-burst with a beat in the output register
    seq.push_back(mk(0,0,8'h00,0, 1,8'hB1,0, 1,  0,0,0, 0,8'h00,0, 0));
    seq.push_back(mk(0,0,8'h00,0, 1,8'hB1,0, 1,  0,1,1, 0,8'h00,0, 1));
    seq.push_back(mk(0,0,8'h00,0, 1,8'hB2,0, 1,  0,1,1, 1,8'hB1,0, 1));
    seq.push_back(mk(1,1,8'hA1,0, 1,8'hB3,0, 1,  0,0,0, 0,8'h00,0, 0));
    seq.push_back(mk(1,1,8'hA1,0, 1,8'hB3,0, 1,  0,0,0, 0,8'h00,0, 0));
    seq.push_back(mk(0,1,8'hA1,0, 1,8'hB3,0, 1,  0,0,0, 0,8'h00,0, 0));
    seq.push_back(mk(0,1,8'hA1,0, 1,8'hB3,0, 1,  1,0,1, 0,8'h00,0, 0));
    run_seq("async_reset");

    do_reset();
    model_reset();
    for (int i = 0; i < 2000; i++) begin
      logic       r_rst;
      logic       r_av;
      logic       r_al;
      logic       r_bv;
      logic       r_bl;
      logic       r_zr;
      logic [7:0] r_ad;
      logic [7:0] r_bd;
      r_rst = ($urandom_range(0, 299) == 0);
      r_av  = ($urandom_range(0, 3) != 0);
      r_bv  = ($urandom_range(0, 3) != 0);
      r_al  = ($urandom_range(0, 2) == 0);
      r_bl  = ($urandom_range(0, 2) == 0);
      r_zr  = ($urandom_range(0, 3) != 0);
      r_ad  = 8'($urandom);
      r_bd  = 8'($urandom);
      @(negedge CLK);
      drive(r_rst, r_av, r_ad, r_al, r_bv, r_bd, r_bl, r_zr);
      #1;
      if (r_rst) model_reset();
      compare("random", i, model_outputs(r_zr));
      if (!r_rst) model_step(r_av, r_ad, r_al, r_bv, r_bd, r_bl, r_zr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
